rrf_freelist: RTL and testbench

//  Allocation/retirement manager for the rename register file (Rrf): the producer side of the Rrf

---
 rtl/rrf_freelist.sv | 88 ++++++++
 tb/tb_rrf_freelist.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rrf_freelist.sv
// Rename register file free-list: circular tag allocation for dispatch, in-order
// retirement on commit, and full rollback of speculative tags on mispredict.
module rrf_freelist #(
   parameter int RRF_NUM = 64,
   parameter int RRF_SEL = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req_num_i,
   input  logic               stall_dp_i,
   input  logic               prmiss_i,
   input  logic [1:0]         comnum_i,
   output logic               alloc_ok_o,
   output logic [RRF_SEL-1:0] dst1_rrftag_o,
   output logic [RRF_SEL-1:0] dst2_rrftag_o,
   output logic               allocate_rrf_en_o,
   output logic [RRF_SEL-1:0] allocate_rrftag_o,
   output logic               allocate2_rrf_en_o,
   output logic [RRF_SEL-1:0] allocate2_rrftag_o,
   output logic [RRF_SEL-1:0] completed_dst_rrftag_o,
   output logic [RRF_SEL-1:0] completed2_rrftag_o,
   output logic [RRF_SEL:0]   freenum_o
);

   localparam logic [RRF_SEL:0]   NUM_W = (RRF_SEL+1)'(RRF_NUM);
   localparam logic [RRF_SEL-1:0] ONE_P = RRF_SEL'(1);

   logic [RRF_SEL-1:0] freeptr, comptr;
   logic [RRF_SEL:0]   freenum;

   logic [1:0]         req, com_raw, com_eff, acnt;
   logic [RRF_SEL:0]   occ, req_x, com_raw_x, com_x, acnt_x;
   logic [RRF_SEL-1:0] com_p, acnt_p, comptr_nxt;
   logic               fire, over_commit;

   always_comb begin
      req         = (req_num_i == 2'd3) ? 2'd0 : req_num_i;
      com_raw     = (comnum_i  == 2'd3) ? 2'd0 : comnum_i;
      occ         = NUM_W - freenum;
      req_x       = {{(RRF_SEL-1){1'b0}}, req};
      com_raw_x   = {{(RRF_SEL-1){1'b0}}, com_raw};
      // Commit can never retire more tags than are actually in flight
      over_commit = (com_raw_x > occ);
      com_eff     = over_commit ? occ[1:0] : com_raw;
      com_x       = {{(RRF_SEL-1){1'b0}}, com_eff};
      com_p       = {{(RRF_SEL-2){1'b0}}, com_eff};
      alloc_ok_o  = (freenum >= req_x);
      fire        = alloc_ok_o & ~stall_dp_i & ~prmiss_i & (req != 2'd0);
      acnt        = fire ? req : 2'd0;
      acnt_x      = {{(RRF_SEL-1){1'b0}}, acnt};
      acnt_p      = {{(RRF_SEL-2){1'b0}}, acnt};
      comptr_nxt  = comptr + com_p;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         freeptr <= '0;
         comptr  <= '0;
         freenum <= NUM_W;
      end else if (prmiss_i) begin
         comptr  <= comptr_nxt;
         freeptr <= comptr_nxt;
         freenum <= NUM_W;
      end else begin
         comptr  <= comptr_nxt;
         freeptr <= freeptr + acnt_p;
         freenum <= freenum + com_x - acnt_x;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (reset && over_commit)
         $display("rrf_freelist: commit of %0d clamped to %0d in-flight tags", com_raw, occ);
   end
`endif

   assign dst1_rrftag_o          = freeptr;
   assign dst2_rrftag_o          = freeptr + ONE_P;
   assign allocate_rrf_en_o      = fire;
   assign allocate2_rrf_en_o     = fire & (req == 2'd2);
   assign allocate_rrftag_o      = dst1_rrftag_o;
   assign allocate2_rrftag_o     = dst2_rrftag_o;
   assign completed_dst_rrftag_o = comptr;
   assign completed2_rrftag_o    = comptr + ONE_P;
   assign freenum_o              = freenum;

endmodule

// File: tb/tb_rrf_freelist.sv
// Directed bench for rrf_freelist: hand-computed expectations for allocation,
// wrap, full/empty boundaries, commit clamp, mispredict rollback and async reset.
module tb_rrf_freelist;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req_num_i, comnum_i;
   logic       stall_dp_i, prmiss_i;
   logic       alloc_ok_o, allocate_rrf_en_o, allocate2_rrf_en_o;
   logic [5:0] dst1_rrftag_o, dst2_rrftag_o, allocate_rrftag_o, allocate2_rrftag_o;
   logic [5:0] completed_dst_rrftag_o, completed2_rrftag_o;
   logic [6:0] freenum_o;

   int nvec = 0;
   int nmis = 0;

   rrf_freelist #(.RRF_NUM(64), .RRF_SEL(6)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .req_num_i              (req_num_i),
      .stall_dp_i             (stall_dp_i),
      .prmiss_i               (prmiss_i),
      .comnum_i               (comnum_i),
      .alloc_ok_o             (alloc_ok_o),
      .dst1_rrftag_o          (dst1_rrftag_o),
      .dst2_rrftag_o          (dst2_rrftag_o),
      .allocate_rrf_en_o      (allocate_rrf_en_o),
      .allocate_rrftag_o      (allocate_rrftag_o),
      .allocate2_rrf_en_o     (allocate2_rrf_en_o),
      .allocate2_rrftag_o     (allocate2_rrftag_o),
      .completed_dst_rrftag_o (completed_dst_rrftag_o),
      .completed2_rrftag_o    (completed2_rrftag_o),
      .freenum_o              (freenum_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [1:0] r, input logic [1:0] c, input logic s, input logic p);
      req_num_i  = r;
      comnum_i   = c;
      stall_dp_i = s;
      prmiss_i   = p;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(2'd0, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " alloc_ok"}, alloc_ok_o, 1);
      chk({tag, " dst1"}, dst1_rrftag_o, 0);
      chk({tag, " dst2"}, dst2_rrftag_o, 1);
      chk({tag, " en"}, allocate_rrf_en_o, 0);
      chk({tag, " en2"}, allocate2_rrf_en_o, 0);
      chk({tag, " comp1"}, completed_dst_rrftag_o, 0);
      chk({tag, " comp2"}, completed2_rrftag_o, 1);
      chk({tag, " freenum"}, freenum_o, 64);
   endtask

   initial begin
      reset = 1'b0;
      drive(2'd0, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk_reset_outs("rst");
      reset = 1'b1;
      #1;

      // 1: single allocations from reset
      for (int unsigned i = 0; i < 3; i++) begin
         drive(2'd1, 2'd0, 1'b0, 1'b0);
         chk("t1 dst1", dst1_rrftag_o, int'(i));
         chk("t1 alloc_tag", allocate_rrftag_o, int'(i));
         chk("t1 en", allocate_rrf_en_o, 1);
         chk("t1 en2", allocate2_rrf_en_o, 0);
         tick();
         chk("t1 freenum", freenum_o, 63 - int'(i));
      end

      // 2: fill completely, then no bypass of same-cycle commit
      do_reset();
      for (int unsigned i = 0; i < 32; i++) begin
         drive(2'd2, 2'd0, 1'b0, 1'b0);
         chk("t2 dst1", dst1_rrftag_o, int'(2 * i));
         chk("t2 dst2", allocate2_rrftag_o, int'(2 * i + 1));
         chk("t2 en2", allocate2_rrf_en_o, 1);
         tick();
      end
      chk("t2 full freenum", freenum_o, 0);
      drive(2'd1, 2'd0, 1'b0, 1'b0);
      chk("t2 full ok", alloc_ok_o, 0);
      chk("t2 full en", allocate_rrf_en_o, 0);
      tick();
      chk("t2 full freenum2", freenum_o, 0);
      drive(2'd1, 2'd1, 1'b0, 1'b0);
      chk("t2 nobypass ok", alloc_ok_o, 0);
      chk("t2 nobypass en", allocate_rrf_en_o, 0);
      tick();
      chk("t2 freed freenum", freenum_o, 1);
      chk("t2 comp1", completed_dst_rrftag_o, 1);
      drive(2'd1, 2'd0, 1'b0, 1'b0);
      chk("t2 regrant ok", alloc_ok_o, 1);
      chk("t2 regrant dst1", dst1_rrftag_o, 0);
      chk("t2 regrant en", allocate_rrf_en_o, 1);
      tick();
      chk("t2 refull freenum", freenum_o, 0);

      // 3: pair grant across the wrap point
      do_reset();
      for (int unsigned i = 0; i < 31; i++) begin
         drive(2'd2, 2'd0, 1'b0, 1'b0);
         tick();
      end
      drive(2'd1, 2'd0, 1'b0, 1'b0);
      tick();
      chk("t3 freenum", freenum_o, 1);
      chk("t3 dst1", dst1_rrftag_o, 63);
      drive(2'd2, 2'd0, 1'b0, 1'b0);
      chk("t3 short ok", alloc_ok_o, 0);
      chk("t3 short en", allocate_rrf_en_o, 0);
      drive(2'd0, 2'd2, 1'b0, 1'b0);
      tick();
      chk("t3 freenum2", freenum_o, 3);
      chk("t3 comp1", completed_dst_rrftag_o, 2);
      drive(2'd2, 2'd0, 1'b0, 1'b0);
      chk("t3 wrap ok", alloc_ok_o, 1);
      chk("t3 wrap dst1", dst1_rrftag_o, 63);
      chk("t3 wrap dst2", dst2_rrftag_o, 0);
      chk("t3 wrap en2", allocate2_rrf_en_o, 1);
      tick();
      chk("t3 wrap freeptr", dst1_rrftag_o, 1);
      chk("t3 wrap freenum", freenum_o, 1);

      // 4: commits then mispredict with a same-cycle commit
      do_reset();
      for (int unsigned i = 0; i < 5; i++) begin
         drive(2'd2, 2'd0, 1'b0, 1'b0);
         tick();
      end
      chk("t4 freenum", freenum_o, 54);
      chk("t4 comp0", completed_dst_rrftag_o, 0);
      drive(2'd0, 2'd2, 1'b0, 1'b0);
      tick();
      chk("t4 comp2", completed_dst_rrftag_o, 2);
      drive(2'd0, 2'd2, 1'b0, 1'b0);
      tick();
      chk("t4 comp4", completed_dst_rrftag_o, 4);
      chk("t4 comp4b", completed2_rrftag_o, 5);
      chk("t4 freenum2", freenum_o, 58);
      drive(2'd2, 2'd1, 1'b0, 1'b1);
      chk("t4 pm en", allocate_rrf_en_o, 0);
      chk("t4 pm en2", allocate2_rrf_en_o, 0);
      tick();
      chk("t4 pm comptr", completed_dst_rrftag_o, 5);
      chk("t4 pm freeptr", dst1_rrftag_o, 5);
      chk("t4 pm freenum", freenum_o, 64);

      // 5: upstream stall blocks allocation
      drive(2'd2, 2'd0, 1'b1, 1'b0);
      chk("t5 ok", alloc_ok_o, 1);
      chk("t5 en", allocate_rrf_en_o, 0);
      chk("t5 en2", allocate2_rrf_en_o, 0);
      tick();
      chk("t5 freeptr", dst1_rrftag_o, 5);
      chk("t5 freenum", freenum_o, 64);

      // 6: over-commit on empty, encoding 3 as zero, then async reset mid-cycle
      drive(2'd0, 2'd2, 1'b0, 1'b0);
      tick();
      chk("t6 clamp comptr", completed_dst_rrftag_o, 5);
      chk("t6 clamp freenum", freenum_o, 64);
      drive(2'd3, 2'd3, 1'b0, 1'b0);
      chk("t6 req3 en", allocate_rrf_en_o, 0);
      tick();
      chk("t6 req3 freenum", freenum_o, 64);
      for (int unsigned i = 0; i < 5; i++) begin
         drive(2'd1, 2'd0, 1'b0, 1'b0);
         tick();
      end
      chk("t6 freenum", freenum_o, 59);
      chk("t6 freeptr", dst1_rrftag_o, 10);
      drive(2'd0, 2'd0, 1'b0, 1'b0);
      #1;
      reset = 1'b0;
      #1;
      chk_reset_outs("t6 async");
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("t6 post freenum", freenum_o, 64);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
